// File: rtl/deco_pkg.sv
// Shared encodings for the synchronous one-hot tap/phase decoder.
package deco_pkg;

    // Update modes applied on an accepted period-boundary load
    localparam logic [1:0] MODE_DIRECT = 2'd0;
    localparam logic [1:0] MODE_ROTATE = 2'd1;
    localparam logic [1:0] MODE_DITHER = 2'd2;
    localparam logic [1:0] MODE_HOLD   = 2'd3;

    // Control FSM states
    localparam logic [1:0] S_OFF    = 2'd0;
    localparam logic [1:0] S_ARM    = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;

endpackage

// File: rtl/deco_onehot.sv
// Combinational SEL_W -> 2**SEL_W one-hot decoder.
module deco_onehot #(
    parameter  int SEL_W = 2,
    localparam int OUT_W = 2 ** SEL_W
) (
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] onehot
);

    // Exactly one bit set for every index value
    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/deco_sync_onehot.sv
// Registered one-hot tap/phase select, updated only on period-boundary loads
// so the delay-line/phase mux never switches mid-PWM-cycle.
module deco_sync_onehot
    import deco_pkg::*;
#(
    parameter  int SEL_W    = 2,
    parameter  int DITHER_W = 2,
    localparam int OUT_W    = 2 ** SEL_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                load,
    input  logic [1:0]          mode,
    input  logic [SEL_W-1:0]    sel_in,
    input  logic [DITHER_W-1:0] frac_in,
    output logic [OUT_W-1:0]    out,
    output logic [SEL_W-1:0]    sel_q,
    output logic                upd
);

    logic [1:0]          state_q, state_d;
    logic [SEL_W-1:0]    sel_d;
    logic [DITHER_W-1:0] dcnt_q, dcnt_d;
    logic [OUT_W-1:0]    out_q, out_d;
    logic                upd_q, upd_d;
    logic                acc;
    logic [SEL_W:0]      dith_sum;
    logic [OUT_W-1:0]    dec_out;

    // FSM: a load is only accepted once armed and while enabled
    always_comb begin
        state_d = state_q;
        acc     = 1'b0;
        case (state_q)
            S_OFF: begin
                // load during the arming cycle is deliberately dropped
                if (en) state_d = S_ARM;
            end
            S_ARM: begin
                if (!en) begin
                    state_d = S_OFF;
                end else if (load) begin
                    state_d = S_ACTIVE;
                    acc     = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (!en) state_d = S_OFF;
                else     acc     = load;
            end
            default: state_d = S_OFF;
        endcase
    end

    // Next index and dither counter; one extra bit catches dither overflow
    always_comb begin
        sel_d    = sel_q;
        dcnt_d   = dcnt_q;
        dith_sum = {1'b0, sel_in} + {{SEL_W{1'b0}}, (dcnt_q < frac_in)};
        if (acc) begin
            case (mode)
                MODE_DIRECT: sel_d = sel_in;
                MODE_ROTATE: sel_d = sel_q + SEL_W'(1);
                MODE_DITHER: begin
                    // saturate at the last tap rather than wrapping to tap 0
                    sel_d  = dith_sum[SEL_W] ? {SEL_W{1'b1}} : dith_sum[SEL_W-1:0];
                    dcnt_d = dcnt_q + DITHER_W'(1);
                end
                default: sel_d = sel_q;
            endcase
        end
    end

    deco_onehot #(.SEL_W(SEL_W)) u_dec (
        .sel    (sel_d),
        .onehot (dec_out)
    );

    // Output select is decoded from the next index so it lands with sel_q
    always_comb begin
        out_d = (state_d == S_ACTIVE) ? dec_out : '0;
        upd_d = acc;
    end

    // State registers, all cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_OFF;
            sel_q   <= '0;
            dcnt_q  <= '0;
            out_q   <= '0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dcnt_q  <= dcnt_d;
            out_q   <= out_d;
            upd_q   <= upd_d;
        end
    end

    assign out = out_q;
    assign upd = upd_q;

endmodule
